// File: rtl/bongo_pkg.sv
// Shared constants for the DK bongo single-wire poller: FSM encodings,
// the poll command word, frame lengths and response field positions.
package bongo_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TX_BIT  = 3'd1;
  localparam logic [2:0] ST_TX_STOP = 3'd2;
  localparam logic [2:0] ST_RX_WAIT = 3'd3;
  localparam logic [2:0] ST_RX_BIT  = 3'd4;
  localparam logic [2:0] ST_RX_STOP = 3'd5;
  localparam logic [2:0] ST_DONE    = 3'd6;

  localparam logic [23:0] POLL_CMD = 24'h400300;

  localparam int unsigned CMD_BITS  = 24;
  localparam int unsigned RESP_BITS = 64;

  localparam int unsigned HIT_MSB    = 63;
  localparam int unsigned HIT_LSB    = 56;
  localparam int unsigned SCREAM_MSB = 23;
  localparam int unsigned SCREAM_LSB = 12;

  // Larger of two unsigned values, used to size shared timing counters.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bongo_edge_sync.sv
// Two-flop synchronizer for a single-wire pad plus a falling-edge pulse.
// The pulse appears two cycles after the pad falls; idle level is high.
module bongo_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fall_c
);

  logic meta;
  logic prev;

  // Synchronizer chain and one-cycle history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall_c = prev & ~sync;

endmodule

// File: rtl/bongo_poller.sv
// Single-wire master for the DK bongo controller: periodically sends the
// poll command on the open-drain line and captures the 64-bit response.
// Optional feature macro: BONGO_RUMBLE_EN adds a rumble input that becomes
// the last command bit, sampled at transaction start.
module bongo_poller
  import bongo_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned POLL_HZ         = 660,
  parameter int unsigned RESP_TIMEOUT_US = 200,
  parameter int unsigned BIT_TIMEOUT_US  = 8
) (
  input  logic        clk,
  input  logic        rst,
  inout  wire         data_io,
  input  logic        poll_en,
`ifdef BONGO_RUMBLE_EN
  input  logic        rumble,
`endif
  output logic [7:0]  hit,
  output logic [11:0] scream,
  output logic        valid,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned US      = CLK_HZ / 1_000_000;
  localparam int unsigned CELL    = 4 * US;
  localparam int unsigned PERIOD  = CLK_HZ / POLL_HZ;
  localparam int unsigned RESP_TO = RESP_TIMEOUT_US * US;
  localparam int unsigned BIT_TO  = BIT_TIMEOUT_US * US;
  localparam int unsigned CNT_MAX = max_u(max_u(CELL, RESP_TO), max_u(PERIOD, BIT_TO));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = 7;

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] poll_cnt;
  logic [BIT_W-1:0] bits, bits_n;
  logic [23:0]      cmd, cmd_n;
  logic [63:0]      resp, resp_n;
  logic             drive_low, drive_n;
  logic [7:0]       hit_n;
  logic [11:0]      scream_n;
  logic             valid_n, timeout_n, busy_n;
  logic             poll_wrap, abort;
  logic [CNT_W-1:0] low_len;
  logic [23:0]      cmd_start;
  logic             line_sync, line_fall_c;

  // Open-drain driver: only ever pulls low.
  assign data_io = drive_low ? 1'b0 : 1'bz;

  bongo_edge_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (data_io),
    .sync   (line_sync),
    .fall_c (line_fall_c)
  );

`ifdef BONGO_RUMBLE_EN
  assign cmd_start = POLL_CMD | {23'd0, rumble};
`else
  assign cmd_start = POLL_CMD;
`endif

  assign poll_wrap = poll_en && (poll_cnt == CNT_W'(PERIOD - 1));

  // Free-running poll interval counter, paused while polling is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      poll_cnt <= '0;
    end else if (poll_en) begin
      poll_cnt <= poll_wrap ? '0 : poll_cnt + CNT_W'(1);
    end
  end

  // Next-state, counter and output decode for the poll transaction.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bits_n    = bits;
    cmd_n     = cmd;
    resp_n    = resp;
    drive_n   = 1'b0;
    hit_n     = hit;
    scream_n  = scream;
    valid_n   = 1'b0;
    timeout_n = timeout;
    busy_n    = busy;
    abort     = 1'b0;
    low_len   = cmd[23] ? CNT_W'(US) : CNT_W'(3 * US);

    case (state)
      ST_IDLE: begin
        if (poll_wrap) begin
          state_n = ST_TX_BIT;
          cnt_n   = '0;
          bits_n  = '0;
          cmd_n   = cmd_start;
          busy_n  = 1'b1;
          drive_n = 1'b1;
        end
      end

      ST_TX_BIT: begin
        if (cnt == CNT_W'(CELL - 1)) begin
          cnt_n   = '0;
          cmd_n   = {cmd[22:0], 1'b0};
          bits_n  = bits + BIT_W'(1);
          drive_n = 1'b1;
          if (bits == BIT_W'(CMD_BITS - 1)) begin
            state_n = ST_TX_STOP;
          end
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          drive_n = (cnt_n < low_len);
        end
      end

      ST_TX_STOP: begin
        if (cnt == CNT_W'(US - 1)) begin
          state_n = ST_RX_WAIT;
          cnt_n   = '0;
        end else begin
          cnt_n   = cnt + CNT_W'(1);
          drive_n = 1'b1;
        end
      end

      ST_RX_WAIT: begin
        if (line_fall_c) begin
          state_n = ST_RX_BIT;
          cnt_n   = '0;
          bits_n  = '0;
        end else if (cnt == CNT_W'(RESP_TO - 1)) begin
          abort = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_RX_BIT: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(2 * US - 1)) begin
          resp_n = {resp[62:0], line_sync};
          bits_n = bits + BIT_W'(1);
          if (bits == BIT_W'(RESP_BITS - 1)) begin
            state_n = ST_RX_STOP;
          end
        end
        if (line_fall_c) begin
          cnt_n = '0;
        end else if (cnt == CNT_W'(BIT_TO - 1)) begin
          abort = 1'b1;
        end
      end

      ST_RX_STOP: begin
        if (line_fall_c) begin
          state_n = ST_DONE;
        end else if (cnt == CNT_W'(BIT_TO - 1)) begin
          abort = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_n   = ST_IDLE;
        hit_n     = resp[HIT_MSB:HIT_LSB];
        scream_n  = resp[SCREAM_MSB:SCREAM_LSB];
        valid_n   = 1'b1;
        timeout_n = 1'b0;
        busy_n    = 1'b0;
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_n   = ST_IDLE;
      timeout_n = 1'b1;
      busy_n    = 1'b0;
    end
  end

  // State register and registered datapath/outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bits      <= '0;
      cmd       <= '0;
      resp      <= '0;
      drive_low <= 1'b0;
      hit       <= '0;
      scream    <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bits      <= bits_n;
      cmd       <= cmd_n;
      resp      <= resp_n;
      drive_low <= drive_n;
      hit       <= hit_n;
      scream    <= scream_n;
      valid     <= valid_n;
      timeout   <= timeout_n;
      busy      <= busy_n;
    end
  end

endmodule
